// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writer side of the instruction-memory interface. A program arrives as a byte
// stream over a valid/ready handshake:
//   LEN_HI, LEN_LO            word count N, big-endian
//   N x (HI byte, LO byte)    program words
//   CSUM                      XOR of all 2N data bytes
// Each word is written into the single-port instruction RAM at consecutive
// addresses starting at BASE_ADDR. The core stays frozen (cpu_halt=1) until a
// load completes with a matching checksum; fetch then runs from BASE_ADDR.
//
// Ports
//   clk         in   1   system clock, all state on rising edge
//   rst         in   1   asynchronous reset, active-low
//   start       in   1   one-cycle pulse, begins a load (IDLE/DONE/ERR only)
//   byte_valid  in   1   byte_data valid this cycle
//   byte_data   in   8   stream byte
//   byte_ready  out  1   loader accepts a byte this cycle (registered)
//   mem_addr    out  16  RAM write address, zero-extended from ADDR_W bits
//   mem_data    out  16  RAM write data
//   mem_wren    out  1   RAM write enable, one cycle per word
//   cpu_halt    out  1   1 = core frozen
//   load_done   out  1   1 = last load finished with good checksum
//   load_err    out  1   1 = last load failed
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        mem_wren,
    output logic        cpu_halt,
    output logic        load_done,
    output logic        load_err
);

    // Number of words that fit between BASE_ADDR and the top of the RAM.
    localparam int unsigned MAX_WORDS = (32'd1 << ADDR_W) - BASE_ADDR;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DAT_HI,
        S_DAT_LO,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               xfer;
    logic [15:0]        len_q;
    logic [15:0]        len_next;
    logic [7:0]         word_hi;
    logic [7:0]         csum_q;
    logic [15:0]        wcnt;
    logic [ADDR_W-1:0]  addr_cur;

    assign xfer     = byte_valid & byte_ready;
    assign len_next = {len_q[15:8], byte_data};
    assign addr_cur = ADDR_W'(BASE_ADDR) + ADDR_W'(wcnt);

    // Status flags are plain decodes of the state register: DONE and ERR are
    // only left through start (which clears them) or reset.
    assign cpu_halt  = (state != S_DONE);
    assign load_done = (state == S_DONE);
    assign load_err  = (state == S_ERR);

    // NOTE: every output of a combinational block gets a default before the
    // case statement; a path that leaves it unassigned would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = S_LEN_HI;
            S_LEN_HI: if (xfer)  next_state = S_LEN_LO;
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_next == 16'd0)
                        next_state = S_CSUM;
                    else if (32'(len_next) > MAX_WORDS)
                        next_state = S_ERR;   // rejected before any write
                    else
                        next_state = S_DAT_HI;
                end
            end
            S_DAT_HI: if (xfer) next_state = S_DAT_LO;
            S_DAT_LO: if (xfer) next_state = S_WRITE;
            S_WRITE:  next_state = (wcnt + 16'd1 == len_q) ? S_CSUM : S_DAT_HI;
            S_CSUM: begin
                if (xfer) next_state = (byte_data == csum_q) ? S_DONE : S_ERR;
            end
            S_DONE:   if (start) next_state = S_LEN_HI;
            S_ERR:    if (start) next_state = S_LEN_HI;
            default:  next_state = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            byte_ready <= 1'b0;
            mem_wren   <= 1'b0;
            mem_addr   <= 16'(BASE_ADDR);
            mem_data   <= 16'd0;
            len_q      <= 16'd0;
            word_hi    <= 8'd0;
            csum_q     <= 8'd0;
            wcnt       <= 16'd0;
        end else begin
            state <= next_state;
            // Registered from the next state so it lines up with the state
            // that will be current when the byte is sampled.
            byte_ready <= next_state inside {S_LEN_HI, S_LEN_LO, S_DAT_HI,
                                             S_DAT_LO, S_CSUM};
            mem_wren   <= 1'b0;

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        len_q  <= 16'd0;
                        csum_q <= 8'd0;
                        wcnt   <= 16'd0;
                    end
                end
                S_LEN_HI: if (xfer) len_q[15:8] <= byte_data;
                S_LEN_LO: if (xfer) len_q[7:0]  <= byte_data;
                S_DAT_HI: begin
                    if (xfer) begin
                        word_hi <= byte_data;
                        csum_q  <= csum_q ^ byte_data;
                    end
                end
                S_DAT_LO: begin
                    // Write strobe, address and data are registered here so
                    // they are all present during the single WRITE cycle and
                    // address/data hold afterwards.
                    if (xfer) begin
                        mem_wren <= 1'b1;
                        mem_data <= {word_hi, byte_data};
                        mem_addr <= 16'(addr_cur);
                        csum_q   <= csum_q ^ byte_data;
                    end
                end
                S_WRITE: wcnt <= wcnt + 16'd1;
                default: ;
            endcase
        end
    end

endmodule
